// File: rtl/repeated_add_multiplier.sv
// Sequential unsigned multiplier: adds A into P once per cycle while B counts down to zero.
// Optional build macro MULT_OVF_FLAG_EN adds a sticky carry-out flag (ovf).
module repeated_add_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] product,
    output logic             done,
    output logic             busy
`ifdef MULT_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             eqz;

`ifdef MULT_OVF_FLAG_EN
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum_c;

    // Returns {carry, sum}; the carry feeds the sticky overflow flag.
    function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    assign sum_c = add_carry(p_q, a_q);
`endif

    assign eqz = (b_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
`ifdef MULT_OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
`ifdef MULT_OVF_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
`ifdef MULT_OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_A;
            end
            LOAD_A: begin
                a_d     = data_in;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                b_d     = data_in;
                p_d     = '0;
`ifdef MULT_OVF_FLAG_EN
                ovf_d   = 1'b0;
`endif
                state_d = ADD;
            end
            ADD: begin
                if (eqz) begin
                    state_d = DONE;
                end else begin
`ifdef MULT_OVF_FLAG_EN
                    p_d   = sum_c[WIDTH-1:0];
                    ovf_d = ovf_q | sum_c[WIDTH];
`else
                    p_d   = p_q + a_q;
`endif
                    b_d   = b_q - 1'b1;
                end
            end
            DONE: begin
                // Start must fall before a new multiply can begin.
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign product = p_q;
    assign done    = (state_q == DONE);
    assign busy    = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == ADD);
`ifdef MULT_OVF_FLAG_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_repeated_add_multiplier.sv
// Directed bench for repeated_add_multiplier: vector table plus hold-start and mid-run reset sequences.
module tb_repeated_add_multiplier;

    localparam int WIDTH = 16;
    localparam int LIMIT = 2000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] product;
    logic             done;
    logic             busy;
`ifdef MULT_OVF_FLAG_EN
    logic             ovf;
`endif

    int checks;
    int failures;

    repeated_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .product (product),
        .done    (done),
        .busy    (busy)
`ifdef MULT_OVF_FLAG_EN
        ,
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] prod;
        logic             ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one multiply; returns the number of clock edges from the start edge until done is seen.
    task automatic do_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit hold, output int lat);
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'hBEEF;
        @(negedge clk);
        if (!hold) start = 1'b0;
        data_in = a;
        check("busy_load_a", {31'd0, busy}, 32'd1);
        @(negedge clk);
        data_in = b;
        @(negedge clk);
        data_in = 16'h5A5A;
        lat = 2;
        while (!done && lat < LIMIT) begin
            @(negedge clk);
            data_in = data_in + 16'h1111;
            lat++;
        end
    endtask

    initial begin
        int lat;
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        data_in  = '0;
        rst_n    = 1'b1;

        vecs[0] = '{a: 16'd17,    b: 16'd5,   prod: 16'd85,    ovf: 1'b0};
        vecs[1] = '{a: 16'd7,     b: 16'd0,   prod: 16'd0,     ovf: 1'b0};
        vecs[2] = '{a: 16'd0,     b: 16'd9,   prod: 16'd0,     ovf: 1'b0};
        vecs[3] = '{a: 16'd300,   b: 16'd300, prod: 16'd24464, ovf: 1'b1};
        vecs[4] = '{a: 16'd3,     b: 16'd4,   prod: 16'd12,    ovf: 1'b0};
        vecs[5] = '{a: 16'd6,     b: 16'd2,   prod: 16'd12,    ovf: 1'b0};
        vecs[6] = '{a: 16'd65535, b: 16'd2,   prod: 16'd65534, ovf: 1'b1};
        vecs[7] = '{a: 16'd1,     b: 16'd1,   prod: 16'd1,     ovf: 1'b0};
        vecs[8] = '{a: 16'd255,   b: 16'd3,   prod: 16'd765,   ovf: 1'b0};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_product", {16'd0, product}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef MULT_OVF_FLAG_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_mult(vecs[i].a, vecs[i].b, 1'b0, lat);
            check($sformatf("latency_%0d", i), lat, 32'(3 + int'(vecs[i].b)));
            check($sformatf("product_%0d", i), {16'd0, product}, {16'd0, vecs[i].prod});
            check($sformatf("busy_in_done_%0d", i), {31'd0, busy}, 32'd0);
`ifdef MULT_OVF_FLAG_EN
            check($sformatf("ovf_%0d", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
`endif
            @(negedge clk);
            check($sformatf("done_drop_%0d", i), {31'd0, done}, 32'd0);
        end

        // Start held high through DONE keeps the result parked.
        do_mult(16'd9, 16'd9, 1'b1, lat);
        check("hold_latency", lat, 32'd12);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_done", {31'd0, done}, 32'd1);
            check("hold_product", {16'd0, product}, 32'd81);
        end
        start = 1'b0;
        @(negedge clk);
        check("hold_release_done", {31'd0, done}, 32'd0);
        check("hold_release_busy", {31'd0, busy}, 32'd0);
        do_mult(16'd3, 16'd4, 1'b0, lat);
        check("after_hold_product", {16'd0, product}, 32'd12);
        check("after_hold_done", {31'd0, done}, 32'd1);

        // Reset asserted in the middle of the 17x5 accumulation.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd17;
        @(negedge clk);
        data_in = 16'd5;
        repeat (3) @(negedge clk);
        check("midrun_busy_before", {31'd0, busy}, 32'd1);
        check("midrun_partial_nonzero", {31'd0, product != 0}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", {16'd0, product}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_mult(16'd6, 16'd2, 1'b0, lat);
        check("restart_latency", lat, 32'd5);
        check("restart_product", {16'd0, product}, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
